// File: rtl/sqrt_poly_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_poly_pkg
//   Shared constants, coefficient tables and helpers for the sqrt_poly pipeline.
//   sqrt(m) on m in [1,4) is approximated with 64 chord segments:
//     32 segments of width 1/32 over [1,2), 32 segments of width 1/16 over [2,4).
//   C0[i] = sqrt(segment start), u2.18, rounded up.
//   C1[i] = (sqrt(end) - sqrt(start)) / width, u1.13, rounded up.
//   A chord always lies below sqrt, so both coefficients are rounded upward.
//   This pulls the worst-case error back toward zero.
//   The tables are computed from exact integer square roots when the design
//   is elaborated, so no hand-typed constants can go stale.
// -----------------------------------------------------------------------------
package sqrt_poly_pkg;

    // Interface formats
    localparam int XW       = 31;   // u7.24 input
    localparam int XFRAC    = 24;
    localparam int YW       = 17;   // u4.13 output
    localparam int YFRAC    = 13;
    localparam int SEG_BITS = 5;    // segments per octave = 2**SEG_BITS
    localparam int SEGS     = 2 * (1 << SEG_BITS);

    // Internal formats
    localparam int MW       = 32;   // normalised mantissa, u2.30
    localparam int MFRAC    = 30;
    localparam int DMW      = 26;   // offset inside a segment, units 2^-30
    localparam int C0W      = 20;   // u2.18
    localparam int C0FRAC   = 18;
    localparam int C1W      = 14;   // u1.13
    localparam int C1FRAC   = 13;
    localparam int PW       = C1W + DMW;         // C1*dm product width
    localparam int PFRAC    = C1FRAC + MFRAC;    // product fraction bits (43)
    localparam int C0_ALIGN = PFRAC - C0FRAC;    // shift C0 onto product scale
    localparam int SW       = PFRAC + 3;         // sum plus rounding headroom
    // Output shift = PFRAC - YFRAC - k, with k = p_half - XFRAC/2.
    // That gives DEN_BASE - p_half, where p_half = leading-one position / 2.
    localparam int DEN_BASE = PFRAC - YFRAC + XFRAC / 2;

    // Scale used for the boundary roots while the tables are built.
    localparam int ROOT_FRAC = 30;

    // Position of the highest set bit; 0 when v is zero (zero flagged separately)
    function automatic logic [4:0] lod31(input logic [XW-1:0] v);
        logic [4:0] pos;
        pos = '0;
        for (int i = 0; i < XW; i++) begin
            if (v[i]) pos = 5'(i);
        end
        return pos;
    endfunction

    // floor(sqrt(n)) for n < 2^64, bit by bit
    function automatic logic [63:0] isqrt64(input logic [63:0] n);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= n) r = t;
        end
        return r;
    endfunction

    // sqrt of a segment boundary, scaled by 2^ROOT_FRAC.
    // edge_off = 0 gives the segment start; edge_off = 1 gives the segment end.
    // Boundaries in [1,2) are (32+i)/32; boundaries in [2,4) are (32+j)/16 = idx/16.
    function automatic logic [63:0] seg_root(input int idx, input int edge_off);
        logic [63:0] n;
        if (idx < 32) n = 64'(32 + idx + edge_off) << 55;   // value * 2^60
        else          n = 64'(idx + edge_off) << 56;
        return isqrt64(n);
    endfunction

    function automatic logic [SEGS*C0W-1:0] gen_c0();
        logic [SEGS*C0W-1:0] r;
        r = '0;
        for (int i = 0; i < SEGS; i++) begin
            // ceil from 2^-30 down to 2^-18
            r[i*C0W +: C0W] = C0W'((seg_root(i, 0) + 64'd4095) >> (ROOT_FRAC - C0FRAC));
        end
        return r;
    endfunction

    function automatic logic [SEGS*C1W-1:0] gen_c1();
        logic [SEGS*C1W-1:0] r;
        logic [63:0]         d;
        r = '0;
        for (int i = 0; i < SEGS; i++) begin
            d = seg_root(i, 1) - seg_root(i, 0);
            // slope*2^13 = d * 2^13 / width / 2^30; width is 2^-5 or 2^-4
            if (i < 32) r[i*C1W +: C1W] = C1W'((d + 64'd4095) >> 12);
            else        r[i*C1W +: C1W] = C1W'((d + 64'd8191) >> 13);
        end
        return r;
    endfunction

    localparam logic [SEGS*C0W-1:0] C0_TAB = gen_c0();
    localparam logic [SEGS*C1W-1:0] C1_TAB = gen_c1();

    function automatic logic [C0W-1:0] c0_rom(input logic [SEG_BITS:0] seg);
        return C0_TAB[seg*C0W +: C0W];
    endfunction

    function automatic logic [C1W-1:0] c1_rom(input logic [SEG_BITS:0] seg);
        return C1_TAB[seg*C1W +: C1W];
    endfunction

endpackage

// File: rtl/sqrt_poly_lod.sv
// -----------------------------------------------------------------------------
// sqrt_poly_lod
//   31-bit leading-one detector. This block is purely combinational.
//   Ports:
//     x     in   31  operand
//     pos   out  5   index of the highest set bit (0 when x is zero)
//     zero  out  1   x is all zeros
// -----------------------------------------------------------------------------
module sqrt_poly_lod
    import sqrt_poly_pkg::*;
(
    input  logic [XW-1:0] x,
    output logic [4:0]    pos,
    output logic          zero
);

    assign pos  = lod31(x);
    assign zero = (x == '0);

endmodule

// File: rtl/sqrt_poly.sv
// -----------------------------------------------------------------------------
// sqrt_poly
//   Pipelined fixed-point square root for the Box-Muller path.
//   The block accepts one sample per clock and has no handshake.
//   The input x is u7.24 and the result is u4.13.
//   x sampled at edge k appears on SqrtValue after edge k+3.
//   Pipeline:
//     edge k   : x_r          <- x
//     edge k+1 : m_r, p_half  <- leading-one detect and normalise to [1,4)
//     edge k+2 : c0_r, prod_r <- coefficient lookup and C1*dm
//     edge k+3 : SqrtValue    <- C0 + C1*dm, denormalise, round, saturate
//   Ports:
//     clk        in   1   rising-edge clock
//     reset      in   1   synchronous, active-high; clears every stage
//     x          in   31  operand, unsigned u7.24
//     SqrtValue  out  17  sqrt(x), unsigned u4.13, registered
// -----------------------------------------------------------------------------
module sqrt_poly
    import sqrt_poly_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] x,
    output logic [YW-1:0] SqrtValue
);

    // ---------------------------------------------------------------- stage 0
    logic [XW-1:0] x_r;

    always_ff @(posedge clk) begin
        if (reset) x_r <= '0;
        else       x_r <= x;
    end

    // ---------------------------------------------------------------- stage 1
    // With p = leading-one position, E = p - 24.
    // Rounding E down to even makes the root shift E'/2 an integer:
    //   E'/2 = p[4:1] - 12.
    // An even p puts the leading one at bit 30, so m is in [1,2).
    // An odd p puts it at bit 31, so m is in [2,4).
    // The normalise shift is therefore 30 - p + p[0].
    logic [4:0]    lod_pos;
    logic          lod_zero;
    logic [4:0]    norm_sh;
    logic [MW-1:0] m_next;

    sqrt_poly_lod u_lod (
        .x    (x_r),
        .pos  (lod_pos),
        .zero (lod_zero)
    );

    always_comb begin
        norm_sh = 5'd30 - lod_pos + {4'b0, lod_pos[0]};
        m_next  = {1'b0, x_r} << norm_sh;
    end

    // nz = 0 forces a zero result.
    // A flushed stage (all zeros) therefore always yields 0 at the output.
    logic [MW-1:0] m_r;
    logic [3:0]    phalf_b;
    logic          nz_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_r     <= '0;
            phalf_b <= '0;
            nz_b    <= 1'b0;
        end else begin
            m_r     <= m_next;
            phalf_b <= lod_pos[4:1];
            nz_b    <= ~lod_zero;
        end
    end

    // ---------------------------------------------------------------- stage 2
    // The segment is selected by the octave bit (m >= 2) plus the next
    // SEG_BITS bits below the leading one.
    // dm is the remainder, still in units of 2^-30, so C1*dm needs no rescaling.
    logic [SEG_BITS:0] seg;
    logic [DMW-1:0]    dm;
    logic [C1W-1:0]    c1;
    logic [PW-1:0]     prod_next;

    always_comb begin
        if (m_r[MW-1]) begin
            seg = {1'b1, m_r[30:26]};
            dm  = m_r[25:0];
        end else begin
            seg = {1'b0, m_r[29:25]};
            dm  = {1'b0, m_r[24:0]};
        end
        c1        = c1_rom(seg);
        prod_next = PW'(c1) * PW'(dm);
    end

    logic [C0W-1:0] c0_r;
    logic [PW-1:0]  prod_r;
    logic [3:0]     phalf_c;
    logic           nz_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            c0_r    <= '0;
            prod_r  <= '0;
            phalf_c <= '0;
            nz_c    <= 1'b0;
        end else begin
            c0_r    <= c0_rom(seg);
            prod_r  <= prod_next;
            phalf_c <= phalf_b;
            nz_c    <= nz_b;
        end
    end

    // ---------------------------------------------------------------- stage 3
    // The sum s is held at 2^-43 resolution.
    // The result is s * 2^k taken to 13 fraction bits, which is a right
    // shift by DEN_BASE - p_half (27..42).
    // Half an output LSB is added before the shift for round-to-nearest.
    logic [SW-1:0] s_sum;
    logic [SW-1:0] s_rnd;
    logic [SW-1:0] y_wide;
    logic [5:0]    den_sh;
    logic [YW-1:0] y_next;

    always_comb begin
        den_sh = 6'(DEN_BASE) - {2'b0, phalf_c};
        s_sum  = SW'({c0_r, {C0_ALIGN{1'b0}}}) + SW'(prod_r);
        s_rnd  = s_sum + (SW'(1) << (den_sh - 6'd1));
        y_wide = s_rnd >> den_sh;
        if (!nz_c)                 y_next = '0;
        else if (|y_wide[SW-1:YW]) y_next = '1;
        else                       y_next = y_wide[YW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) SqrtValue <= '0;
        else       SqrtValue <= y_next;
    end

endmodule

// File: tb/tb_sqrt_poly.sv
// -----------------------------------------------------------------------------
// tb_sqrt_poly
//   Self-checking bench for sqrt_poly.
//   The reference is the real-valued square root rounded to 13 fraction bits.
//   The bench keeps a record of what was applied at each of the last four
//   clock edges. Any output whose window holds a reset must read 0.
//   Every other output must match sqrt of the sample taken three edges earlier.
// -----------------------------------------------------------------------------
module tb_sqrt_poly;

    logic        clk;
    logic        reset;
    logic [30:0] x;
    logic [16:0] SqrtValue;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [30:0] xv;
        logic        rst;
    } samp_t;

    samp_t hist[$];

    sqrt_poly dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .SqrtValue (SqrtValue)
    );

    // ------------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------ reference model
    function automatic int ref_sqrt(input logic [30:0] xv);
        real r;
        int  v;
        r = $sqrt(real'(xv) / 16777216.0) * 8192.0;
        v = $rtoi($floor(r + 0.5));
        if (v > 131071) v = 131071;
        return v;
    endfunction

    // Even powers of two have m = 1.0 exactly, so these inputs must be exact.
    function automatic bit exact_point(input logic [30:0] xv);
        return (xv == 31'h0) || (xv == 31'h01000000) || (xv == 31'h04000000);
    endfunction

    // ------------------------------------------------------ checker
    task automatic check_val(input string tag, input int got, input int exp, input int tol);
        int d;
        n_vec++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // ------------------------------------------------------ driver
    // Drive one sample, let it be captured on the next edge, then check the
    // output that edge produced.
    task automatic tick(input logic [30:0] xv, input logic rv);
        bit any_rst;
        x     = xv;
        reset = rv;
        @(posedge clk);
        hist.push_front('{xv, rv});
        if (hist.size() > 4) void'(hist.pop_back());
        #1;
        if (hist.size() == 4) begin
            any_rst = 1'b0;
            foreach (hist[i]) if (hist[i].rst) any_rst = 1'b1;
            if (any_rst) begin
                check_val("flushed", int'(SqrtValue), 0, 0);
            end else begin
                check_val($sformatf("sqrt(%h)", hist[3].xv), int'(SqrtValue),
                          ref_sqrt(hist[3].xv), exact_point(hist[3].xv) ? 0 : 2);
            end
        end
    endtask

    // ------------------------------------------------------ stimulus
    logic [30:0] dir_vals[7];
    logic [30:0] xv;
    logic [30:0] rv;
    int          p;

    initial begin
        dir_vals = '{31'h7FFFFFFF, 31'h01000000, 31'h04000000, 31'h02000000,
                     31'h09000000, 31'h23000000, 31'h00000000};
        x     = '0;
        reset = 1'b1;

        // reset held: output must be 0
        for (int i = 0; i < 6; i++) tick(31'($urandom()), 1'b1);

        // directed values back to back
        for (int i = 0; i < 7; i++) tick(dir_vals[i], 1'b0);

        // same stream again with a one-cycle reset in the middle
        for (int i = 0; i < 14; i++) tick(dir_vals[i % 7], (i == 5));

        // extremes
        tick(31'h00000001, 1'b0);
        tick(31'h00000002, 1'b0);
        tick(31'h00000003, 1'b0);
        tick(31'h40000000, 1'b0);
        tick(31'h3FFFFFFF, 1'b0);
        tick(31'h10000000, 1'b0);

        // random sweep across all octaves, with the odd stray reset
        for (int n = 0; n < 20000; n++) begin
            p  = $urandom_range(0, 30);
            rv = 31'($urandom());
            if ($urandom_range(0, 7) == 0) xv = rv;
            else xv = (31'd1 << p) | (rv & ((31'd1 << p) - 31'd1));
            tick(xv, ($urandom_range(0, 999) == 0));
        end

        // drain the pipeline
        for (int i = 0; i < 4; i++) tick(31'h01000000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
